// File: rtl/fq_ingress.sv
// fq_ingress: steers length-prefixed bursts into per-flow show-ahead FIFOs, admitting or dropping each burst whole.
// Optional dropped-burst counter port enabled by FQ_INGRESS_DROP_CNT_EN.
module fq_ingress #(
    parameter int NUM_IN_LOG2 = 3,
    parameter int DEPTH_LOG2  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sop,
    input  logic [NUM_IN_LOG2-1:0] in_flow,
    input  logic [63:0]            in_data,
    input  logic                   fifo_rdreq [2**NUM_IN_LOG2],
    output logic                   fifo_empty [2**NUM_IN_LOG2],
    output logic [63:0]            fifo_data  [2**NUM_IN_LOG2],
    output logic                   proto_err
`ifdef FQ_INGRESS_DROP_CNT_EN
    ,
    output logic [31:0]            drop_count
`endif
);
    localparam int NF    = 2**NUM_IN_LOG2;
    localparam int DEPTH = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_V = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
    localparam logic [DEPTH_LOG2:0]   OCC_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_PASS, S_DROP} state_t;

    state_t                 r_state, w_next;
    logic                   r_ready, r_perr;
    logic [7:0]             r_rem;
    logic [NUM_IN_LOG2-1:0] r_cur_flow;
    logic [DEPTH_LOG2:0]    w_occ [NF];
    logic                   w_acc, w_sop, w_cnt_zero, w_admit, w_pop_f, w_wr, w_perr;
    logic [7:0]             w_cnt;
    logic [DEPTH_LOG2:0]    w_free;
    logic [NUM_IN_LOG2-1:0] w_wflow;

    assign in_ready   = r_ready;
    assign proto_err  = r_perr;
    assign w_acc      = in_valid && r_ready && !rst;
    assign w_sop      = w_acc && in_sop;
    assign w_cnt      = in_data[7:0];
    assign w_cnt_zero = (w_cnt == 8'd0);
    // A same-cycle pop of the target flow counts as freed space for admission.
    assign w_pop_f    = fifo_rdreq[in_flow] && (w_occ[in_flow] != '0);
    assign w_free     = DEPTH_V - w_occ[in_flow] + {{DEPTH_LOG2{1'b0}}, w_pop_f};
    assign w_admit    = 32'(w_free) >= 32'(w_cnt);
    assign w_wflow    = in_sop ? in_flow : r_cur_flow;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // A sop is always handled as if from IDLE, whatever state it interrupts.
    always_comb begin
        w_next = r_state;
        if (w_sop) begin
            if (w_cnt_zero || w_cnt == 8'd1) w_next = S_IDLE;
            else                             w_next = w_admit ? S_PASS : S_DROP;
        end else if (w_acc && r_state != S_IDLE && r_rem == 8'd1) begin
            w_next = S_IDLE;
        end
    end

    always_comb begin
        w_wr   = 1'b0;
        w_perr = 1'b0;
        if (w_sop) begin
            w_perr = (r_state != S_IDLE) || w_cnt_zero;
            w_wr   = !w_cnt_zero && w_admit;
        end else if (w_acc) begin
            w_perr = (r_state == S_IDLE);
            w_wr   = (r_state == S_PASS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready    <= 1'b0;
            r_perr     <= 1'b0;
            r_rem      <= '0;
            r_cur_flow <= '0;
        end else begin
            r_ready <= 1'b1;
            r_perr  <= w_perr;
            if (w_sop) begin
                r_cur_flow <= in_flow;
                r_rem      <= w_cnt_zero ? 8'd0 : w_cnt - 8'd1;
            end else if (w_acc && r_state != S_IDLE) begin
                r_rem <= r_rem - 8'd1;
            end
        end
    end

`ifdef FQ_INGRESS_DROP_CNT_EN
    logic        w_drop;
    logic [31:0] r_drop_count;
    assign w_drop     = w_sop && !w_cnt_zero && !w_admit;
    assign drop_count = r_drop_count;
    always_ff @(posedge clk) begin
        if (rst)                                   r_drop_count <= '0;
        else if (w_drop && r_drop_count != '1)     r_drop_count <= r_drop_count + 32'd1;
    end
`endif

    for (genvar i = 0; i < NF; i++) begin : g_fifo
        logic [63:0]           r_mem [DEPTH];
        logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
        logic [DEPTH_LOG2:0]   r_occ;
        logic                  w_push, w_pop;

        assign w_push = w_wr && (w_wflow == NUM_IN_LOG2'(i));
        assign w_pop  = fifo_rdreq[i] && (r_occ != '0);

        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wptr] <= in_data;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_occ  <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PTR_ONE;
                if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
                if (w_push && !w_pop)      r_occ <= r_occ + OCC_ONE;
                else if (!w_push && w_pop) r_occ <= r_occ - OCC_ONE;
            end
        end

        assign w_occ[i]      = r_occ;
        assign fifo_empty[i] = (r_occ == '0);
        assign fifo_data[i]  = r_mem[r_rptr];
    end
endmodule

// File: tb/tb_fq_ingress.sv
// tb_fq_ingress: directed + random bursts checked every cycle against a queue-based model of fq_ingress.
module tb_fq_ingress;
    localparam int NF    = 8;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_sop = 1'b0;
    logic        in_ready;
    logic [2:0]  in_flow = '0;
    logic [63:0] in_data = '0;
    logic        fifo_rdreq [NF];
    logic        fifo_empty [NF];
    logic [63:0] fifo_data  [NF];
    logic        proto_err;
`ifdef FQ_INGRESS_DROP_CNT_EN
    logic [31:0] drop_count;
`endif

    int checks = 0, errors = 0;

    // Model: one queue per flow plus the burst being framed.
    logic [63:0] mq [NF][$];
    int          mmode;   // 0 idle, 1 passing, 2 dropping
    int          mleft;   // records still expected in current burst
    int          mflow;
    bit          mready, mperr;
    logic [31:0] mdrop;

    fq_ingress #(.NUM_IN_LOG2(3), .DEPTH_LOG2(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sop(in_sop), .in_flow(in_flow), .in_data(in_data),
        .fifo_rdreq(fifo_rdreq), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .proto_err(proto_err)
`ifdef FQ_INGRESS_DROP_CNT_EN
        , .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit v, input bit s, input logic [2:0] f,
                              input logic [63:0] d, input logic [7:0] rd);
        int c, pop_f;
        bit wr;
        int wf;
        mperr = 0;
        if (r) begin
            for (int i = 0; i < NF; i++) mq[i].delete();
            mmode = 0; mleft = 0; mflow = 0; mdrop = '0; mready = 0;
            return;
        end
        wr = 0; wf = 0;
        if (v && mready) begin
            if (s) begin
                if (mmode != 0) mperr = 1;
                c = int'(d[7:0]);
                mflow = int'(f);
                pop_f = (rd[f] && mq[f].size() > 0) ? 1 : 0;
                if (c == 0) begin
                    mperr = 1; mmode = 0;
                end else if (DEPTH - mq[f].size() + pop_f >= c) begin
                    wr = 1; wf = int'(f); mleft = c - 1; mmode = (c == 1) ? 0 : 1;
                end else begin
                    if (mdrop != 32'hFFFF_FFFF) mdrop = mdrop + 1;
                    mleft = c - 1; mmode = (c == 1) ? 0 : 2;
                end
            end else if (mmode == 0) begin
                mperr = 1;
            end else begin
                if (mmode == 1) begin wr = 1; wf = mflow; end
                mleft--;
                if (mleft == 0) mmode = 0;
            end
        end
        for (int i = 0; i < NF; i++)
            if (rd[i] && mq[i].size() > 0) void'(mq[i].pop_front());
        if (wr) mq[wf].push_back(d);
        mready = 1;
    endtask

    task automatic check_all();
        chk("in_ready", {63'd0, in_ready}, {63'd0, mready});
        chk("proto_err", {63'd0, proto_err}, {63'd0, mperr});
        for (int i = 0; i < NF; i++) begin
            chk($sformatf("empty[%0d]", i), {63'd0, fifo_empty[i]}, {63'd0, mq[i].size() == 0});
            if (mq[i].size() > 0) chk($sformatf("data[%0d]", i), fifo_data[i], mq[i][0]);
        end
`ifdef FQ_INGRESS_DROP_CNT_EN
        chk("drop_count", {32'd0, drop_count}, {32'd0, mdrop});
`endif
    endtask

    task automatic cyc(input bit r, input bit v, input bit s, input logic [2:0] f,
                       input logic [63:0] d, input logic [7:0] rd);
        rst = r; in_valid = v; in_sop = s; in_flow = f; in_data = d;
        for (int i = 0; i < NF; i++) fifo_rdreq[i] = rd[i];
        model_edge(r, v, s, f, d, rd);
        @(posedge clk);
        #1;
        check_all();
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] sopd(input logic [7:0] c);
        logic [63:0] d;
        d = rnd64();
        d[7:0] = c;
        return d;
    endfunction

    task automatic burst(input logic [2:0] f, input int c, input int nbody, input logic [7:0] rd);
        cyc(0, 1, 1, f, sopd(8'(c)), rd);
        for (int k = 0; k < nbody; k++) cyc(0, 1, 0, f, rnd64(), 8'h00);
    endtask

    initial begin
        for (int i = 0; i < NF; i++) fifo_rdreq[i] = 1'b0;
        mmode = 0; mleft = 0; mflow = 0; mready = 0; mperr = 0; mdrop = '0;

        cyc(1, 0, 0, 0, 64'd0, 8'h00);
        cyc(1, 0, 0, 0, 64'd0, 8'h00);
        cyc(0, 0, 0, 0, 64'd0, 8'h00);

        // basic 3-record burst into flow 2, then drain
        burst(3'd2, 3, 2, 8'h00);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 64'd0, 8'h04);

        // fill flow 5 to 30, overflowing burst dropped whole, then an exact fit
        burst(3'd5, 30, 29, 8'h00);
        burst(3'd5, 3, 2, 8'h00);
        burst(3'd5, 2, 1, 8'h00);

        // full flow 1 admits a 1-record burst when popped in the same cycle
        burst(3'd1, 32, 31, 8'h00);
        cyc(0, 1, 1, 3'd1, sopd(8'd1), 8'h02);
        cyc(0, 0, 0, 0, 64'd0, 8'h00);

        // sop interrupting a burst
        burst(3'd0, 4, 1, 8'h00);
        burst(3'd3, 1, 0, 8'h00);
        cyc(0, 0, 0, 0, 64'd0, 8'h00);

        // framing errors in IDLE
        cyc(0, 1, 0, 3'd6, rnd64(), 8'h00);
        cyc(0, 1, 1, 3'd6, sopd(8'd0), 8'h00);
        cyc(0, 0, 0, 0, 64'd0, 8'h00);
        for (int k = 0; k < 40; k++) cyc(0, 0, 0, 0, 64'd0, 8'hFF);

        // reset mid-burst, then a fresh burst
        burst(3'd4, 5, 1, 8'h00);
        cyc(1, 1, 0, 3'd4, rnd64(), 8'h00);
        cyc(0, 1, 0, 3'd4, rnd64(), 8'h00);
        burst(3'd6, 2, 1, 8'h00);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 64'd0, 8'h40);

        // random traffic: light draining first so flows fill up, then heavier
        for (int n = 0; n < 800; n++) begin
            bit          v, s;
            int          c;
            logic [63:0] d;
            logic [7:0]  rd;
            v = ($urandom() % 5) != 0;
            s = (mmode == 0) ? (($urandom() % 8) != 0) : (($urandom() % 20) == 0);
            c = (($urandom() % 10) == 0) ? int'($urandom() % 40) : int'(1 + $urandom() % 6);
            d = rnd64();
            if (s) d[7:0] = 8'(c);
            if (n < 400) rd = 8'($urandom() & $urandom() & $urandom() & $urandom());
            else         rd = 8'($urandom() & $urandom());
            cyc(0, v, s, 3'($urandom()), d, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fq_ingress.md
Name: fq_ingress

Overview:
- Ingress buffer bank directly upstream of the fair-queue scheduler.
- Accepts a single stream of 64-bit records grouped into bursts, and steers each burst into one of 2**NUM_IN_LOG2 per-flow show-ahead FIFOs.
- Each burst's first record carries the burst length in data[7:0]. A burst is admitted whole or dropped whole, so the scheduler never sees a partial burst.
- Read side drives the scheduler's fifo_rdreq / fifo_empty / fifo_data interface directly.

Parameters:
- NUM_IN_LOG2, 3: log2 of flow count. Sets the number of FIFOs and the width of in_flow.
- DEPTH_LOG2, 5: log2 of per-flow FIFO depth in 64-bit records (default 32 entries).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input record present
- in_ready  output  1  input record accepted this cycle when in_valid&&in_ready
- in_sop  input  1  first record of a burst
- in_flow  input  NUM_IN_LOG2  destination flow; sampled only with in_sop
- in_data  input  64  record; data[7:0] = burst count on the sop record
- fifo_rdreq  input  1 x 2**NUM_IN_LOG2 (unpacked)  pop head of flow i
- fifo_empty  output  1 x 2**NUM_IN_LOG2 (unpacked)  flow i has no records
- fifo_data  output  64 x 2**NUM_IN_LOG2 (unpacked)  head record of flow i, valid when !fifo_empty[i]
- proto_err  output  1  one-cycle pulse on an input framing violation
- drop_count  output  32  dropped-burst counter (only with the optional feature)

Behaviour:
- Reset values:
  - in_ready=0; proto_err=0; drop_count=0.
  - All FIFOs empty: fifo_empty[i]=1, occupancy=0, pointers=0.
  - fifo_data[i] is don't-care while empty.
  - FSM goes to IDLE, rem=0, cur_flow=0.
- in_ready=1 every cycle after reset. The block never backpressures; it drops instead.
- Ingress FSM states, with all transitions on accepted records only:
  - IDLE:
    - A non-sop record asserts proto_err and is discarded; stay in IDLE.
    - A sop record with count c: set cur_flow=in_flow.
    - If c==0, assert proto_err, discard, stay in IDLE.
    - Else if free(cur_flow) >= c: write the record, set rem=c-1, go to PASS (or stay in IDLE if c==1).
    - Else: discard, set rem=c-1, go to DROP (or stay in IDLE if c==1). Each dropped burst increments drop_count once.
  - PASS:
    - A non-sop record is written to cur_flow and rem decrements; at rem==1 go to IDLE.
  - DROP:
    - A non-sop record is discarded and rem decrements; at rem==1 go to IDLE.
  - PASS or DROP receiving sop:
    - Assert proto_err. Records already written stay in the FIFO.
    - The new sop is then processed as in IDLE in the same cycle.
- free(f) = 2**DEPTH_LOG2 - occ(f). occ is DEPTH_LOG2+1 bits wide.
  - The check uses the occupancy at the sop cycle, including a pop of that flow in the same cycle.
  - Admission reserves space. The bursts are contiguous per admission, so no FIFO can overflow.
  - c > 2**DEPTH_LOG2 is always dropped.
- Per-flow FIFO:
  - Circular buffer; pointers are DEPTH_LOG2 bits wide and wrap naturally.
  - Write latency: a record written at edge N appears on fifo_data/!fifo_empty after edge N (visible in cycle N+1).
  - Show-ahead: fifo_data[i] always presents the head entry.
  - fifo_rdreq[i] pops at the next edge. The following entry is visible in the next cycle.
  - rdreq while empty is ignored, with no underflow and no occupancy change.
  - A simultaneous write and pop on the same flow leaves occ unchanged. If occ was 1, the new record becomes head next cycle.
- drop_count saturates at 32'hFFFF_FFFF.
- Reset mid-burst empties all FIFOs and discards the burst. Records arriving in the reset cycle are ignored.

Optional Feature:
- Macro FQ_INGRESS_DROP_CNT_EN.
- Defined: drop_count port exists and counts as above.
- Undefined: drop_count port and counter are absent; drop behaviour is otherwise identical.

Test Plan:
- Flow 2 empty; sop count=3 then 2 records -> 3 records in flow 2 in order; fifo_empty[2] falls one cycle after the first write; pop 3 times -> fifo_empty[2]=1.
- Fill flow 5 to 30/32; send a count=3 burst to flow 5 -> whole burst dropped, occ stays 30, drop_count=1; next count=2 burst is accepted, occ=32.
- Flow 1 at occ=32 with rdreq[1]=1 in the same cycle as a sop count=1 burst -> admitted, occ stays 32.
- sop count=4 to flow 0, 2 records, then sop count=1 to flow 3 -> proto_err pulses; flow 0 holds 2 records; flow 3 holds 1 record.
- Non-sop record in IDLE, then sop with count=0 -> proto_err on each, no writes, drop_count unchanged.
- rst asserted mid-burst after 2 writes -> all fifo_empty=1, drop_count=0, FSM IDLE; a fresh burst works normally.
